mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-port requester and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if;
  logic        iReq0, iReq1;
  logic [31:0] iAddr0, iAddr1;
  logic [31:0] iWData0, iWData1;
  logic        iRW0, iRW1;
  logic        oAck0, oAck1;
  logic [31:0] oRData0, oRData1;
  logic        oErr;
  logic [31:0] oMemAddr;
  logic [31:0] oMemData;
  logic        oMemRW;
  logic        oMemEn;
  logic [31:0] iMemData;
  logic        iMemReady;

  modport master (
    output iReq0, iReq1, iAddr0, iAddr1, iWData0, iWData1, iRW0, iRW1,
    output iMemData, iMemReady,
    input  oAck0, oAck1, oRData0, oRData1, oErr,
    input  oMemAddr, oMemData, oMemRW, oMemEn
  );

  modport slave (
    input  iReq0, iReq1, iAddr0, iAddr1, iWData0, iWData1, iRW0, iRW1,
    input  iMemData, iMemReady,
    output oAck0, oAck1, oRData0, oRData1, oErr,
    output oMemAddr, oMemData, oMemRW, oMemEn
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter with fair tie-break and wait timeout
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic         iClk,
  input  logic         iRst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t      state, state_next;
  logic        last;
  logic [7:0]  wait_cnt;
  logic [31:0] addr_q, wdata_q;
  logic        rw_q;
  logic        ack0_q, ack1_q, err_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        grant0, grant1, done_ok, done_to;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, the port that did not complete last gets the grant
        if (bus.iReq0 && (!bus.iReq1 || last)) begin
          grant0     = 1'b1;
          state_next = BUSY0;
        end else if (bus.iReq1) begin
          grant1     = 1'b1;
          state_next = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        if (bus.iMemReady) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          done_to    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      last     <= 1'b1;
      wait_cnt <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rw_q     <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err_q  <= 1'b0;
      if (grant0 || grant1) begin
        addr_q   <= grant0 ? bus.iAddr0  : bus.iAddr1;
        wdata_q  <= grant0 ? bus.iWData0 : bus.iWData1;
        rw_q     <= grant0 ? bus.iRW0    : bus.iRW1;
        wait_cnt <= 8'd0;
      end else if (state != IDLE && !done_ok && !done_to) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (done_ok || done_to) begin
        last  <= (state == BUSY1);
        err_q <= done_to;
        if (state == BUSY0) begin
          ack0_q <= 1'b1;
          if (rw_q) rdata0_q <= done_ok ? bus.iMemData : 32'd0;
        end else begin
          ack1_q <= 1'b1;
          if (rw_q) rdata1_q <= done_ok ? bus.iMemData : 32'd0;
        end
      end
    end
  end

  assign bus.oMemEn   = (state != IDLE);
  assign bus.oMemAddr = addr_q;
  assign bus.oMemData = wdata_q;
  assign bus.oMemRW   = rw_q;
  assign bus.oAck0    = ack0_q;
  assign bus.oAck1    = ack1_q;
  assign bus.oErr     = err_q;
  assign bus.oRData0  = rdata0_q;
  assign bus.oRData1  = rdata1_q;

endmodule
